audio_i2s_frame_scheduler: RTL and testbench

AUDIO_I2S_FRAME_SCHEDULER -- requirements
Module: audio_i2s_frame_scheduler

---
 rtl/audio_i2s_frame_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_audio_i2s_frame_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_frame_scheduler.sv
// audio_i2s_frame_scheduler: 64-bit-clock I2S frame timing, LR clock generation,
// and a stereo-pair FIFO that feeds the serializer once per frame.
//
// Ports:
//   iAUD_BCLK         bit clock, all state on posedge
//   reset_reg_N       asynchronous active-low reset
//   i_enable          run request (level)
//   i_clear_underrun  one-cycle pulse, clears underrun flag and counter
//   i_sample_valid    producer offers a stereo pair
//   i_l_sample/i_r_sample   producer left/right sample
//   o_sample_ready    FIFO can accept a pair this cycle
//   o_sample_req      one-cycle per-frame request strobe to the producer
//   o_aud_daclrck     LR clock, 0 = left half of the frame
//   o_lsound_out/o_rsound_out  pair presented to the serializer for this frame
//   o_fifo_level      number of occupied FIFO entries
//   o_underrun        sticky underrun flag
//   o_underrun_cnt    saturating underrun count
//   o_running         high in RUN and DRAIN
module audio_i2s_frame_scheduler #(
    parameter int AUD_BIT_DEPTH = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                         iAUD_BCLK,
    input  logic                         reset_reg_N,
    input  logic                         i_enable,
    input  logic                         i_clear_underrun,
    input  logic                         i_sample_valid,
    input  logic [AUD_BIT_DEPTH-1:0]     i_l_sample,
    input  logic [AUD_BIT_DEPTH-1:0]     i_r_sample,
    output logic                         o_sample_ready,
    output logic                         o_sample_req,
    output logic                         o_aud_daclrck,
    output logic [AUD_BIT_DEPTH-1:0]     o_lsound_out,
    output logic [AUD_BIT_DEPTH-1:0]     o_rsound_out,
    output logic [$clog2(FIFO_DEPTH):0]  o_fifo_level,
    output logic                         o_underrun,
    output logic [15:0]                  o_underrun_cnt,
    output logic                         o_running
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int DW = 2 * AUD_BIT_DEPTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [5:0]       bitcnt, bitcnt_nxt;
    logic             lrck;
    logic [LW-1:0]    level;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [DW-1:0]    mem [FIFO_DEPTH];
    logic [AUD_BIT_DEPTH-1:0] l_out, r_out;
    logic             underrun;
    logic [15:0]      underrun_cnt;

    logic frame_end;
    logic fifo_empty;
    logic push, pop;
    logic pop_req, prime;
    logic underrun_evt;
    logic enter_idle;

    assign frame_end  = (bitcnt == 6'd63);
    assign fifo_empty = (level == '0);

    assign o_sample_ready = (level < LW'(FIFO_DEPTH));
    assign push = i_sample_valid & o_sample_ready;

    // A continuing RUN frame (including DRAIN cancelled at the boundary)
    // consumes a pair and may underrun; the SYNC->RUN boundary only primes
    // the first pair so the first RUN frame already carries audio.
    assign pop_req = frame_end
                     & ((state == RUN) | ((state == DRAIN) & i_enable));
    assign prime   = frame_end & (state == SYNC) & i_enable;
    assign pop     = (pop_req | prime) & ~fifo_empty;
    assign underrun_evt = pop_req & fifo_empty;

    assign enter_idle = (state != IDLE) & (state_nxt == IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (i_enable) state_nxt = SYNC;
            SYNC: begin
                if (!i_enable)      state_nxt = IDLE;
                else if (frame_end) state_nxt = RUN;
            end
            RUN:   if (!i_enable) state_nxt = DRAIN;
            DRAIN: begin
                if (i_enable)       state_nxt = RUN;
                else if (frame_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bitcnt_nxt = bitcnt + 6'd1;
        if (state == IDLE || state_nxt == IDLE)
            bitcnt_nxt = 6'd0;
    end

    always_ff @(posedge iAUD_BCLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state  <= IDLE;
            bitcnt <= 6'd0;
            lrck   <= 1'b0;
        end else begin
            state  <= state_nxt;
            bitcnt <= bitcnt_nxt;
            lrck   <= bitcnt_nxt[5];
        end
    end

    always_ff @(posedge iAUD_BCLK) begin
        if (push)
            mem[wr_ptr] <= {i_l_sample, i_r_sample};
    end

    always_ff @(posedge iAUD_BCLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge iAUD_BCLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            l_out <= '0;
            r_out <= '0;
        end else if (pop) begin
            {l_out, r_out} <= mem[rd_ptr];
        end else if (underrun_evt || enter_idle) begin
            l_out <= '0;
            r_out <= '0;
        end
    end

    // A new underrun wins over a coincident clear, restarting the count at 1.
    always_ff @(posedge iAUD_BCLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            underrun     <= 1'b0;
            underrun_cnt <= 16'd0;
        end else if (underrun_evt) begin
            underrun <= 1'b1;
            if (i_clear_underrun)
                underrun_cnt <= 16'd1;
            else if (underrun_cnt != 16'hFFFF)
                underrun_cnt <= underrun_cnt + 16'd1;
        end else if (i_clear_underrun) begin
            underrun     <= 1'b0;
            underrun_cnt <= 16'd0;
        end
    end

    assign o_sample_req   = ((state == SYNC) | (state == RUN))
                            & (bitcnt == 6'd0) & o_sample_ready;
    assign o_aud_daclrck  = lrck;
    assign o_lsound_out   = l_out;
    assign o_rsound_out   = r_out;
    assign o_fifo_level   = level;
    assign o_underrun     = underrun;
    assign o_underrun_cnt = underrun_cnt;
    assign o_running      = (state == RUN) | (state == DRAIN);

endmodule

// File: tb/tb_audio_i2s_frame_scheduler.sv
// tb_audio_i2s_frame_scheduler: directed scenario bench for the I2S frame scheduler.
// Each task drives one scenario and checks hand-computed expectations inline.
module tb_audio_i2s_frame_scheduler;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        valid;
    logic [31:0] l_in;
    logic [31:0] r_in;
    logic        ready;
    logic        req;
    logic        lrck;
    logic [31:0] l_out;
    logic [31:0] r_out;
    logic [2:0]  level;
    logic        urun;
    logic [15:0] ucnt;
    logic        running;

    int vec;
    int miss;

    audio_i2s_frame_scheduler #(
        .AUD_BIT_DEPTH(32),
        .FIFO_DEPTH(4)
    ) dut (
        .iAUD_BCLK(clk),
        .reset_reg_N(rst_n),
        .i_enable(en),
        .i_clear_underrun(clr),
        .i_sample_valid(valid),
        .i_l_sample(l_in),
        .i_r_sample(r_in),
        .o_sample_ready(ready),
        .o_sample_req(req),
        .o_aud_daclrck(lrck),
        .o_lsound_out(l_out),
        .o_rsound_out(r_out),
        .o_fifo_level(level),
        .o_underrun(urun),
        .o_underrun_cnt(ucnt),
        .o_running(running)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        clr = 1'b0;
        valid = 1'b0;
        l_in = '0;
        r_in = '0;
        tick();
        tick();
        vec++;
        if ({ready, req, lrck, running, urun} !== 5'b10000) begin
            miss++;
            $display("FAIL reset_flags got %b want %b",
                     {ready, req, lrck, running, urun}, 5'b10000);
        end
        vec++;
        if (level !== 3'd0) begin
            miss++;
            $display("FAIL reset_level got %0d want 0", level);
        end
        vec++;
        if ({l_out, r_out} !== 64'd0) begin
            miss++;
            $display("FAIL reset_samples got %h want 0", {l_out, r_out});
        end
        vec++;
        if (ucnt !== 16'd0) begin
            miss++;
            $display("FAIL reset_cnt got %h want 0", ucnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sync_order();
        valid = 1'b1;
        l_in = 32'h11111111;
        r_in = 32'h22222222;
        tick();
        l_in = 32'h33333333;
        r_in = 32'h44444444;
        tick();
        valid = 1'b0;
        vec++;
        if (level !== 3'd2 || req !== 1'b0) begin
            miss++;
            $display("FAIL preload got level=%0d req=%b want level=2 req=0",
                     level, req);
        end
        en = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) begin
            vec++;
            if ({l_out, r_out} !== 64'd0 || running !== 1'b0) begin
                miss++;
                $display("FAIL sync_zero[%0d] got %h run=%b want 0 run=0",
                         i, {l_out, r_out}, running);
            end
            vec++;
            if (lrck !== (i >= 32) || req !== (i == 0)) begin
                miss++;
                $display("FAIL sync_lrck_req[%0d] got lrck=%b req=%b want %b %b",
                         i, lrck, req, (i >= 32), (i == 0));
            end
            tick();
        end
        vec++;
        if (running !== 1'b1 || level !== 3'd1 || req !== 1'b1) begin
            miss++;
            $display("FAIL run_entry got run=%b level=%0d req=%b want 1 1 1",
                     running, level, req);
        end
        for (int i = 0; i < 64; i++) begin
            vec++;
            if ({l_out, r_out} !== 64'h11111111_22222222 || lrck !== (i >= 32)) begin
                miss++;
                $display("FAIL frame0[%0d] got %h lrck=%b want %h lrck=%b",
                         i, {l_out, r_out}, lrck, 64'h11111111_22222222, (i >= 32));
            end
            tick();
        end
        vec++;
        if ({l_out, r_out} !== 64'h33333333_44444444 || level !== 3'd0) begin
            miss++;
            $display("FAIL frame1 got %h level=%0d want %h level=0",
                     {l_out, r_out}, level, 64'h33333333_44444444);
        end
    endtask

    task automatic test_underrun();
        repeat (64) tick();
        vec++;
        if ({l_out, r_out} !== 64'd0 || urun !== 1'b1 || ucnt !== 16'd1) begin
            miss++;
            $display("FAIL underrun1 got %h flag=%b cnt=%0d want 0 1 1",
                     {l_out, r_out}, urun, ucnt);
        end
        repeat (128) tick();
        vec++;
        if (urun !== 1'b1 || ucnt !== 16'd3) begin
            miss++;
            $display("FAIL underrun3 got flag=%b cnt=%0d want 1 3", urun, ucnt);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vec++;
        if (urun !== 1'b0 || ucnt !== 16'd0) begin
            miss++;
            $display("FAIL clear got flag=%b cnt=%0d want 0 0", urun, ucnt);
        end
        repeat (62) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vec++;
        if (urun !== 1'b1 || ucnt !== 16'd1) begin
            miss++;
            $display("FAIL clear_vs_underrun got flag=%b cnt=%0d want 1 1",
                     urun, ucnt);
        end
    endtask

    task automatic test_full();
        valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            l_in = 32'hA0000000 + k;
            r_in = 32'hB0000000 + k;
            tick();
        end
        vec++;
        if (level !== 3'd4 || ready !== 1'b0) begin
            miss++;
            $display("FAIL full got level=%0d ready=%b want 4 0", level, ready);
        end
        l_in = 32'hC0DEC0DE;
        r_in = 32'hDEADBEEF;
        tick();
        vec++;
        if (level !== 3'd4) begin
            miss++;
            $display("FAIL fifth_ignored got level=%0d want 4", level);
        end
        repeat (58) tick();
        tick();
        valid = 1'b0;
        vec++;
        if (level !== 3'd3 || ready !== 1'b1) begin
            miss++;
            $display("FAIL push_pop_full got level=%0d ready=%b want 3 1",
                     level, ready);
        end
        vec++;
        if ({l_out, r_out} !== 64'hA0000000_B0000000) begin
            miss++;
            $display("FAIL pop_head got %h want %h",
                     {l_out, r_out}, 64'hA0000000_B0000000);
        end
    endtask

    task automatic test_drain();
        repeat (10) tick();
        en = 1'b0;
        tick();
        vec++;
        if (running !== 1'b1 || {l_out, r_out} !== 64'hA0000000_B0000000) begin
            miss++;
            $display("FAIL drain_hold got run=%b out=%h want 1 %h",
                     running, {l_out, r_out}, 64'hA0000000_B0000000);
        end
        repeat (52) tick();
        vec++;
        if (running !== 1'b1 || lrck !== 1'b1 || level !== 3'd3) begin
            miss++;
            $display("FAIL drain_end got run=%b lrck=%b level=%0d want 1 1 3",
                     running, lrck, level);
        end
        tick();
        vec++;
        if (running !== 1'b0 || lrck !== 1'b0 || {l_out, r_out} !== 64'd0
            || level !== 3'd3) begin
            miss++;
            $display("FAIL drain_idle got run=%b lrck=%b out=%h level=%0d want 0 0 0 3",
                     running, lrck, {l_out, r_out}, level);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            vec++;
            if (lrck !== 1'b0 || req !== 1'b0) begin
                miss++;
                $display("FAIL idle_hold[%0d] got lrck=%b req=%b want 0 0",
                         i, lrck, req);
            end
        end
    endtask

    task automatic test_reset_mid();
        en = 1'b1;
        tick();
        repeat (40) tick();
        vec++;
        if (lrck !== 1'b1 || level !== 3'd3) begin
            miss++;
            $display("FAIL pre_reset got lrck=%b level=%0d want 1 3", lrck, level);
        end
        #2;
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        vec++;
        if (level !== 3'd0 || lrck !== 1'b0 || running !== 1'b0 || ready !== 1'b1) begin
            miss++;
            $display("FAIL async_reset got level=%0d lrck=%b run=%b ready=%b want 0 0 0 1",
                     level, lrck, running, ready);
        end
        vec++;
        if (urun !== 1'b0 || ucnt !== 16'd0) begin
            miss++;
            $display("FAIL async_reset_urun got flag=%b cnt=%0d want 0 0", urun, ucnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_resume();
        en = 1'b1;
        valid = 1'b1;
        l_in = 32'h55555555;
        r_in = 32'h66666666;
        tick();
        l_in = 32'h77777777;
        r_in = 32'h88888888;
        tick();
        valid = 1'b0;
        repeat (63) tick();
        vec++;
        if ({l_out, r_out} !== 64'h55555555_66666666 || level !== 3'd1) begin
            miss++;
            $display("FAIL resume_first got %h level=%0d want %h 1",
                     {l_out, r_out}, level, 64'h55555555_66666666);
        end
        repeat (5) tick();
        en = 1'b0;
        tick();
        repeat (3) tick();
        en = 1'b1;
        tick();
        vec++;
        if (running !== 1'b1 || {l_out, r_out} !== 64'h55555555_66666666) begin
            miss++;
            $display("FAIL resume_run got run=%b out=%h want 1 %h",
                     running, {l_out, r_out}, 64'h55555555_66666666);
        end
        repeat (54) tick();
        vec++;
        if ({l_out, r_out} !== 64'h77777777_88888888 || level !== 3'd0
            || lrck !== 1'b0 || running !== 1'b1) begin
            miss++;
            $display("FAIL resume_next got %h level=%0d lrck=%b run=%b want %h 0 0 1",
                     {l_out, r_out}, level, lrck, running, 64'h77777777_88888888);
        end
    endtask

    task automatic test_saturate();
        force dut.underrun_cnt = 16'hFFFE;
        #1;
        release dut.underrun_cnt;
        #1;
        vec++;
        if (ucnt !== 16'hFFFE) begin
            miss++;
            $display("FAIL preset_cnt got %h want fffe", ucnt);
        end
        repeat (64) tick();
        vec++;
        if (ucnt !== 16'hFFFF || urun !== 1'b1) begin
            miss++;
            $display("FAIL sat1 got cnt=%h flag=%b want ffff 1", ucnt, urun);
        end
        repeat (64) tick();
        vec++;
        if (ucnt !== 16'hFFFF) begin
            miss++;
            $display("FAIL sat2 got cnt=%h want ffff", ucnt);
        end
    endtask

    initial begin
        vec = 0;
        miss = 0;
        test_reset();
        test_sync_order();
        test_underrun();
        test_full();
        test_drain();
        test_reset_mid();
        test_resume();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
